// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU: command codes,
// FSM state encoding and divide-by-zero result constant.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_NOR   = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  // divu by zero returns all ones; sliced to WIDTH by the user (WIDTH <= 64).
  // remu by zero returns the dividend, which the restoring datapath yields
  // on its own, so no constant is needed for it.
  localparam logic [63:0] DIV0_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle. Only built when ALU_MULDIV_EN is defined.
// start loads operands; WIDTH steps follow. The last step is held while
// 'hold' is high so a stalled output register is never overwritten; 'res'
// is the value after the last step and is valid whenever 'last' is high.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,     // [1]=divide, [0]=high half / remainder
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt;
  logic               is_div, sel, dz;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   quo, rem, dvsr, quo_nxt, rem_nxt, diff;
  logic [WIDTH:0]     trial, sum;
  logic               q_bit, step;

  assign last = (cnt == CW'(1));
  assign step = (cnt != '0) && !(last && hold);

  // One multiply step and one restoring-divide step, from current registers
  always_comb begin
    trial    = {rem, quo[WIDTH-1]};
    q_bit    = (trial >= {1'b0, dvsr});
    // trial < 2*dvsr whenever q_bit is set, so the low WIDTH bits suffice
    diff     = trial[WIDTH-1:0] - dvsr;
    rem_nxt  = q_bit ? diff : trial[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], q_bit};
    sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {sum, prod[WIDTH-1:1]};
  end

  // Result select, taken from the post-step values
  always_comb begin
    if (is_div) res = sel ? rem_nxt : (dz ? DIV0_QUO[WIDTH-1:0] : quo_nxt);
    else        res = sel ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      sel    <= 1'b0;
      dz     <= 1'b0;
      prod   <= '0;
      mcand  <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      is_div <= op[1];
      sel    <= op[0];
      dz     <= (b == '0);
      prod   <= {{WIDTH{1'b0}}, a};
      mcand  <= b;
      quo    <= a;
      rem    <= '0;
      dvsr   <= b;
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (is_div) begin
        quo <= quo_nxt;
        rem <= rem_nxt;
      end else begin
        prod <= prod_nxt;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU with valid/ready handshakes and a registered
// result/zero flag. Single-cycle ops are combinational into the output
// register; mul/mulhu/divu/remu go through alu_muldiv_iter when the
// ALU_MULDIV_EN macro is defined, otherwise those codes yield 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       cmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_t           state, next_state;
  logic             out_free, accept, load_out;
  logic [WIDTH-1:0] simple_res, load_val;
  logic [SHW-1:0]   shamt;

  assign shamt    = in2[SHW-1:0];
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  logic             start, is_md, md_last;
  logic [WIDTH-1:0] md_res;

  assign is_md = (cmd[3:2] == 2'b11);
  assign busy  = (state != IDLE);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (cmd[1:0]),
    .a     (in1),
    .b     (in2),
    .hold  (!out_free),
    .last  (md_last),
    .res   (md_res)
  );
`else
  assign busy = 1'b0;
`endif

  // Single-cycle datapath; unknown codes (and muldiv codes here) give 0
  always_comb begin
    simple_res = '0;
    case (cmd)
      ALU_ADD: simple_res = in1 + in2;
      ALU_SUB: simple_res = in1 - in2;
      ALU_AND: simple_res = in1 & in2;
      ALU_OR:  simple_res = in1 | in2;
      ALU_NOR: simple_res = ~(in1 | in2);
      ALU_XOR: simple_res = in1 ^ in2;
      ALU_SLL: simple_res = in1 << shamt;
      ALU_SRA: simple_res = $signed(in1) >>> shamt;
      ALU_SRL: simple_res = in1 >> shamt;
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: simple_res = '0;
      default: simple_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, iteration start and output-register load
  always_comb begin
    next_state = state;
    load_out   = 1'b0;
    load_val   = simple_res;
`ifdef ALU_MULDIV_EN
    start      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MULDIV_EN
          if (is_md) begin
            start      = 1'b1;
            next_state = cmd[1] ? DIV : MUL;
          end else begin
            load_out = 1'b1;
          end
`else
          load_out = 1'b1;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      MUL, DIV: begin
        // Final step retires straight into the output register once it is free
        if (md_last && out_free) begin
          load_out   = 1'b1;
          load_val   = md_res;
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Output register: load takes priority, which also covers drain+accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else if (load_out) begin
      out_valid <= 1'b1;
      result    <= load_val;
      zero      <= (load_val == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
